// File: rtl/motor_arbiter.sv
// Motor drive arbiter: picks one owner (SAFE > MAN > NAV > NONE) and sequences direction changes via duty ramps.
// Define MOTOR_ARB_MANUAL_EN to let the manual requester take part in arbitration.

module motor_arbiter #(
    parameter logic [19:0] STOP_DIST   = 20'd15,
    parameter logic [19:0] CLEAR_DIST  = 20'd25,
    parameter logic [23:0] HOLD_CYCLES = 24'd5_000_000,
    parameter logic [15:0] RAMP_DIV    = 16'd1000,
    parameter logic [9:0]  RAMP_STEP   = 10'd8,
    parameter logic [9:0]  DUTY_MAX    = 10'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [19:0] distance,
    input  logic        dist_valid,
    input  logic        nav_req,
    input  logic [2:0]  nav_mode,
    input  logic        man_req,
    input  logic [2:0]  man_mode,
    output logic [2:0]  motor_mode,
    output logic [9:0]  duty,
    output logic [1:0]  grant,
    output logic        obstacle,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_RDN   = 3'd2,
        S_RUP   = 3'd3,
        S_ESTOP = 3'd4
    } state_t;

    localparam logic [2:0] M_STOP = 3'd0;
    localparam logic [2:0] M_BACK = 3'd4;
    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_NAV  = 2'd1;
    localparam logic [1:0] G_MAN  = 2'd2;
    localparam logic [1:0] G_SAFE = 2'd3;

    function automatic logic [9:0] duty_inc(input logic [9:0] d);
        logic [10:0] sum;
        sum = {1'b0, d} + {1'b0, RAMP_STEP};
        if (sum > {1'b0, DUTY_MAX}) return DUTY_MAX;
        return sum[9:0];
    endfunction

    function automatic logic [9:0] duty_dec(input logic [9:0] d);
        logic signed [10:0] diff;
        diff = $signed({1'b0, d}) - $signed({1'b0, RAMP_STEP});
        if (diff[10]) return '0;
        if (diff[9:0] > DUTY_MAX) return DUTY_MAX;
        return diff[9:0];
    endfunction

    // Modes 5..7 have no H-bridge meaning and collapse to STOP.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        return (m > M_BACK) ? M_STOP : m;
    endfunction

    state_t      state, state_d;
    logic [2:0]  mode_d, tgt_q, tgt_d;
    logic [9:0]  duty_d, duty_up, duty_dn;
    logic [1:0]  grant_d;
    logic        busy_d;
    logic [15:0] presc, presc_d;
    logic [23:0] hold;
    logic [2:0]  req_mode, win_mode, acc_mode;
    logic [1:0]  req_grant, win_grant, acc_grant;
    logic        accept;

`ifdef MOTOR_ARB_MANUAL_EN
    always_comb begin
        req_mode  = M_STOP;
        req_grant = G_NONE;
        if (man_req) begin
            req_mode  = norm_mode(man_mode);
            req_grant = G_MAN;
        end else if (nav_req) begin
            req_mode  = norm_mode(nav_mode);
            req_grant = G_NAV;
        end
    end
`else
    logic unused_man;
    assign unused_man = ^{man_req, man_mode};

    always_comb begin
        req_mode  = M_STOP;
        req_grant = G_NONE;
        if (nav_req) begin
            req_mode  = norm_mode(nav_mode);
            req_grant = G_NAV;
        end
    end
`endif

    // A reversing requester is allowed to back away from the obstacle.
    always_comb begin
        win_mode  = req_mode;
        win_grant = req_grant;
        if (obstacle && req_mode != M_BACK) begin
            win_mode  = M_STOP;
            win_grant = G_SAFE;
        end
    end

    assign accept    = (win_grant >= grant) || (hold == '0);
    assign acc_grant = accept ? win_grant : grant;
    assign acc_mode  = accept ? win_mode  : tgt_q;
    assign duty_up   = duty_inc(duty);
    assign duty_dn   = duty_dec(duty);

    always_comb begin
        state_d = state;
        mode_d  = motor_mode;
        duty_d  = duty;
        grant_d = grant;
        presc_d = presc;
        tgt_d   = tgt_q;
        if (!enable) begin
            state_d = S_IDLE;
            mode_d  = M_STOP;
            duty_d  = '0;
            grant_d = G_NONE;
            presc_d = '0;
            tgt_d   = M_STOP;
        end else if (state != S_IDLE && state != S_ESTOP && win_grant == G_SAFE) begin
            state_d = S_ESTOP;
            mode_d  = M_STOP;
            duty_d  = '0;
            grant_d = G_SAFE;
            presc_d = '0;
            tgt_d   = M_STOP;
        end else begin
            case (state)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    grant_d = acc_grant;
                    tgt_d   = acc_mode;
                    presc_d = '0;
                    if (acc_mode != motor_mode) begin
                        if (motor_mode == M_STOP || duty == '0) begin
                            mode_d  = acc_mode;
                            state_d = (acc_mode == M_STOP) ? S_RUN : S_RUP;
                        end else begin
                            state_d = S_RDN;
                        end
                    end else if (motor_mode != M_STOP && duty != DUTY_MAX) begin
                        state_d = S_RUP;
                    end
                end
                S_RDN: begin
                    grant_d = acc_grant;
                    tgt_d   = acc_mode;
                    if (presc == RAMP_DIV - 16'd1) begin
                        presc_d = '0;
                        duty_d  = duty_dn;
                        if (duty_dn == '0) begin
                            mode_d  = acc_mode;
                            state_d = (acc_mode == M_STOP) ? S_RUN : S_RUP;
                        end
                    end else begin
                        presc_d = presc + 16'd1;
                    end
                end
                S_RUP: begin
                    grant_d = acc_grant;
                    tgt_d   = acc_mode;
                    if (acc_mode != motor_mode) begin
                        presc_d = '0;
                        state_d = S_RDN;
                    end else if (presc == RAMP_DIV - 16'd1) begin
                        presc_d = '0;
                        duty_d  = duty_up;
                        if (duty_up == DUTY_MAX) state_d = S_RUN;
                    end else begin
                        presc_d = presc + 16'd1;
                    end
                end
                S_ESTOP: begin
                    grant_d = G_SAFE;
                    if (win_grant != G_SAFE) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
        busy_d = (state_d == S_RDN) || (state_d == S_RUP) || (state_d == S_ESTOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            motor_mode <= M_STOP;
            duty       <= '0;
            grant      <= G_NONE;
            busy       <= 1'b0;
            obstacle   <= 1'b0;
            presc      <= '0;
            hold       <= '0;
            tgt_q      <= M_STOP;
        end else begin
            state      <= state_d;
            motor_mode <= mode_d;
            duty       <= duty_d;
            grant      <= grant_d;
            busy       <= busy_d;
            presc      <= presc_d;
            tgt_q      <= tgt_d;
            if (dist_valid) begin
                if (distance < STOP_DIST)        obstacle <= 1'b1;
                else if (distance >= CLEAR_DIST) obstacle <= 1'b0;
            end
            if (grant_d != grant)  hold <= HOLD_CYCLES;
            else if (hold != '0)   hold <= hold - 24'd1;
        end
    end

endmodule

// File: tb/tb_motor_arbiter.sv
// Bench for motor_arbiter: directed ramp/estop/hold sequence, then random traffic
// checked against a hysteresis model and behavioural invariants.

module tb_motor_arbiter;

    localparam int STEP = 256;
    localparam int DMAX = 1023;
    localparam int HOLD = 16;
    localparam int DIV  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [19:0] distance;
    logic        dist_valid;
    logic        nav_req;
    logic [2:0]  nav_mode;
    logic        man_req;
    logic [2:0]  man_mode;
    logic [2:0]  motor_mode;
    logic [9:0]  duty;
    logic [1:0]  grant;
    logic        obstacle;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    motor_arbiter #(
        .STOP_DIST  (20'd15),
        .CLEAR_DIST (20'd25),
        .HOLD_CYCLES(24'd16),
        .RAMP_DIV   (16'd4),
        .RAMP_STEP  (10'd256),
        .DUTY_MAX   (10'd1023)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .distance  (distance),
        .dist_valid(dist_valid),
        .nav_req   (nav_req),
        .nav_mode  (nav_mode),
        .man_req   (man_req),
        .man_mode  (man_mode),
        .motor_mode(motor_mode),
        .duty      (duty),
        .grant     (grant),
        .obstacle  (obstacle),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int up_val(input int k);
        return (k * STEP > DMAX) ? DMAX : k * STEP;
    endfunction

    function automatic int dn_val(input int start, input int k);
        return (start - k * STEP < 0) ? 0 : start - k * STEP;
    endfunction

    task automatic strobe(input int d);
        dist_valid = 1'b1;
        distance   = 20'(d);
        tick();
        dist_valid = 1'b0;
    endtask

    initial begin
        int estop_cyc;
        int g0;
        bit obs_m;
        bit en_drv;
        logic [2:0] prev_mode;

        rst = 1'b1; enable = 1'b0; distance = '0; dist_valid = 1'b0;
        nav_req = 1'b0; nav_mode = 3'd0; man_req = 1'b0; man_mode = 3'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_mode", motor_mode, 0);
        chk("rst_duty", duty, 0);
        chk("rst_grant", grant, 0);
        chk("rst_obstacle", obstacle, 0);
        chk("rst_busy", busy, 0);

        // Forward ramp from standstill
        enable = 1'b1; nav_req = 1'b1; nav_mode = 3'd1;
        tick();
        tick();
        chk("fwd_grant", grant, 1);
        chk("fwd_mode", motor_mode, 1);
        chk("fwd_busy", busy, 1);
        chk("fwd_duty0", duty, 0);
        for (int k = 1; k <= 4; k++) begin
            repeat (DIV) tick();
            chk("fwd_ramp", duty, up_val(k));
        end
        chk("fwd_settled", busy, 0);

        // Direction change FORWARD -> LEFT through zero
        nav_mode = 3'd2;
        tick();
        chk("turn_busy", busy, 1);
        chk("turn_mode_hold", motor_mode, 1);
        for (int k = 1; k <= 4; k++) begin
            for (int j = 0; j < DIV; j++) begin
                tick();
                if (duty != 10'd0) chk("no_reverse_at_speed", motor_mode, 1);
            end
            chk("turn_down", duty, dn_val(DMAX, k));
            chk("turn_mode", motor_mode, (k < 4) ? 1 : 2);
        end
        for (int k = 1; k <= 4; k++) begin
            repeat (DIV) tick();
            chk("turn_up", duty, up_val(k));
            chk("turn_up_mode", motor_mode, 2);
        end
        chk("turn_settled", busy, 0);

        // Obstacle: flag after 1 cycle, estop after 2, hysteresis, then hold before NAV regains
        strobe(10);
        chk("obs_set", obstacle, 1);
        chk("obs_duty_lat", duty, DMAX);
        tick();
        estop_cyc = cyc;
        chk("estop_duty", duty, 0);
        chk("estop_mode", motor_mode, 0);
        chk("estop_grant", grant, 3);
        chk("estop_busy", busy, 1);
        strobe(20);
        chk("obs_hyst", obstacle, 1);
        chk("estop_stay", grant, 3);
        strobe(30);
        chk("obs_clear", obstacle, 0);
        tick();
        chk("estop_exit_busy", busy, 0);
        chk("estop_exit_duty", duty, 0);
        while (grant != 2'd1 && cyc - estop_cyc < 40) tick();
        chk("hold_after_estop", cyc - estop_cyc, HOLD + 1);
        chk("resume_mode", motor_mode, 2);
        repeat (4 * DIV) tick();
        chk("resume_duty", duty, DMAX);
        chk("resume_busy", busy, 0);

`ifdef MOTOR_ARB_MANUAL_EN
        // MAN preempts immediately; NAV waits out the hold time
        man_req = 1'b1; man_mode = 3'd2;
        tick();
        g0 = cyc;
        chk("man_grant", grant, 2);
        chk("man_duty", duty, DMAX);
        repeat (2) tick();
        man_req = 1'b0;
        while (grant != 2'd1 && cyc - g0 < 40) tick();
        chk("nav_regain", cyc - g0, HOLD + 1);
        // BACK passes through an obstacle
        man_req = 1'b1; man_mode = 3'd4;
        strobe(10);
        repeat (8 * DIV) tick();
        chk("back_obstacle", obstacle, 1);
        chk("back_grant", grant, 2);
        chk("back_mode", motor_mode, 4);
        chk("back_duty", duty, DMAX);
        chk("back_busy", busy, 0);
`else
        // Manual requester is ignored in this build
        man_req = 1'b1; man_mode = 3'd4;
        g0 = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("man_ignored_grant", grant, 1);
            chk("man_ignored_mode", motor_mode, 2);
        end
        chk("man_ignored_g0", g0, 0);
`endif
        man_req = 1'b0;

        // Obstacle strobe and disable in the same cycle -> IDLE
        enable = 1'b0;
        strobe(5);
        chk("dis_obs_mode", motor_mode, 0);
        chk("dis_obs_duty", duty, 0);
        chk("dis_obs_grant", grant, 0);
        chk("dis_obs_busy", busy, 0);
        chk("dis_obs_flag", obstacle, 1);

        // Reset in the middle of a ramp
        enable = 1'b1;
        strobe(40);
        tick();
        repeat (DIV) tick();
        chk("pre_rst_duty", duty, STEP);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_mode", motor_mode, 0);
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_obs", obstacle, 0);
        rst = 1'b0;

        // Random traffic
        obs_m = 1'b0;
        prev_mode = 3'd0;
        for (int i = 0; i < 1500; i++) begin
            en_drv     = ($urandom_range(0, 59) != 0);
            enable     = en_drv;
            dist_valid = ($urandom_range(0, 5) == 0);
            distance   = 20'($urandom_range(0, 40));
            if ($urandom_range(0, 19) == 0) begin
                nav_req  = 1'($urandom_range(0, 1));
                nav_mode = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 29) == 0) begin
                man_req  = 1'($urandom_range(0, 1));
                man_mode = 3'($urandom_range(0, 7));
            end
            if (dist_valid) begin
                if (distance < 20'd15)       obs_m = 1'b1;
                else if (distance >= 20'd25) obs_m = 1'b0;
            end
            tick();
            chk("rnd_obstacle", obstacle, obs_m);
            if (!en_drv) begin
                chk("rnd_dis_duty", duty, 0);
                chk("rnd_dis_grant", grant, 0);
                chk("rnd_dis_busy", busy, 0);
            end
            if (motor_mode != prev_mode) chk("rnd_mode_change_at_zero", duty, 0);
            if (!busy) chk("rnd_settled_duty", (duty == 10'd0 || duty == 10'd1023), 1);
            chk("rnd_mode_range", (motor_mode <= 3'd4), 1);
`ifndef MOTOR_ARB_MANUAL_EN
            chk("rnd_grant_no_man", (grant == 2'd2), 0);
`endif
            prev_mode = motor_mode;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
